pll_reset_sequencer: RTL and testbench

- Sits beside the core's clock-generation PLL and consumes its asynchronous `locked` output.
- Runs on the free-running 50 MHz reference clock, so it keeps operating while the PLL is unlocked.
- Qualifies lock stability, then sequences a stretched core reset, counts lock-loss events, and requests a PLL reset if lock never arrives.
- Drives the core-wide reset and ready flag consumed by the game logic.

---
 rtl/pll_reset_sequencer.sv | 109 ++++++++++
 tb/tb_pll_reset_sequencer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL lock qualifier and core reset sequencer on the free-running reference clock.
// Stretches core reset after a stable lock and kicks the PLL if lock never comes.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_STABLE    = 1024,
  parameter int RESET_HOLD     = 4096,
  parameter int LOCK_TIMEOUT   = 1000000,
  parameter int PLL_RST_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             ext_reset,
  output logic             pll_rst,
  output logic             core_reset,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [2:0]       state_dbg
);

  localparam int M_QH = (LOCK_STABLE > RESET_HOLD) ? LOCK_STABLE : RESET_HOLD;
  localparam int M_TP = (LOCK_TIMEOUT > PLL_RST_CYCLES) ?
                        LOCK_TIMEOUT : PLL_RST_CYCLES;
  localparam int T_MAX = (M_QH > M_TP) ? M_QH : M_TP;
  localparam int TW = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] T_TIMEOUT = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_PLLRST  = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] T_STABLE  = TW'(LOCK_STABLE - 1);
  localparam logic [TW-1:0] T_HOLD    = TW'(RESET_HOLD - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    PLL_RESET = 3'd1,
    QUALIFY   = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t                 state;
  state_t                 state_n;
  logic [TW-1:0]          timer;
  logic [TW-1:0]          timer_n;
  logic [CNT_W-1:0]       cnt_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  assign locked_s  = sync_q[SYNC_STAGES-1];
  assign state_dbg = state;

  always_comb begin
    state_n = state;
    timer_n = timer + TW'(1);
    cnt_n   = lock_loss_cnt;
    unique case (state)
      WAIT_LOCK: begin
        if (locked_s)                state_n = QUALIFY;
        else if (timer == T_TIMEOUT) state_n = PLL_RESET;
      end
      PLL_RESET: begin
        if (timer == T_PLLRST) state_n = WAIT_LOCK;
      end
      QUALIFY: begin
        if (!locked_s)              state_n = WAIT_LOCK;
        else if (timer == T_STABLE) state_n = HOLD;
      end
      HOLD: begin
        // Lock loss wins over a host reset request.
        if (!locked_s)            state_n = WAIT_LOCK;
        else if (ext_reset)       timer_n = '0;
        else if (timer == T_HOLD) state_n = RUN;
      end
      RUN: begin
        timer_n = '0;
        if (!locked_s) begin
          state_n = WAIT_LOCK;
          if (lock_loss_cnt != {CNT_W{1'b1}})
            cnt_n = lock_loss_cnt + CNT_W'(1);
        end else if (ext_reset) begin
          state_n = HOLD;
        end
      end
      default: state_n = WAIT_LOCK;
    endcase
    if (state_n != state) timer_n = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_LOCK;
      timer         <= '0;
      sync_q        <= '0;
      pll_rst       <= 1'b0;
      core_reset    <= 1'b1;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      sync_q        <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      pll_rst       <= (state_n == PLL_RESET);
      core_reset    <= (state_n != RUN);
      ready         <= (state_n == RUN);
      lock_loss_cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with a cycle-level reference model.
// Scenario tasks check latencies directly; a monitor compares every cycle.
module tb_pll_reset_sequencer;

  localparam int SS   = 2;
  localparam int LS   = 8;
  localparam int RH   = 16;
  localparam int LT   = 100;
  localparam int PRC  = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_locked = 1'b0;
  logic          ext_reset = 1'b0;
  logic          pll_rst;
  logic          core_reset;
  logic          ready;
  logic [CW-1:0] lock_loss_cnt;
  logic [2:0]    state_dbg;

  int checks = 0;
  int failures = 0;
  bit mon_en = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES(SS), .LOCK_STABLE(LS), .RESET_HOLD(RH),
    .LOCK_TIMEOUT(LT), .PLL_RST_CYCLES(PRC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .ext_reset(ext_reset), .pll_rst(pll_rst),
    .core_reset(core_reset), .ready(ready),
    .lock_loss_cnt(lock_loss_cnt), .state_dbg(state_dbg)
  );

  always #10 clk = ~clk;

  // Reference model: states use the published state_dbg numbering,
  // m_age counts whole cycles spent in the current state.
  int m_st = 0;
  int m_age = 0;
  int m_cnt = 0;
  bit m_q[$];

  always @(posedge clk) begin
    bit ls;
    int nx;
    if (rst) begin
      m_st = 0;
      m_age = 0;
      m_cnt = 0;
      m_q.delete();
      repeat (SS) m_q.push_back(1'b0);
    end else begin
      ls = m_q.pop_front();
      m_q.push_back(pll_locked);
      nx = m_st;
      case (m_st)
        0: if (ls) nx = 2; else if (m_age + 1 >= LT) nx = 1;
        1: if (m_age + 1 >= PRC) nx = 0;
        2: if (!ls) nx = 0; else if (m_age + 1 >= LS) nx = 3;
        3: if (!ls) nx = 0;
           else if (!ext_reset && m_age + 1 >= RH) nx = 4;
        4: if (!ls) begin
             nx = 0;
             m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
           end else if (ext_reset) nx = 3;
        default: nx = 0;
      endcase
      if (nx != m_st || (m_st == 3 && ls && ext_reset)) m_age = 0;
      else m_age++;
      m_st = nx;
    end
  end

  int mon_prints = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (state_dbg !== 3'(m_st) || pll_rst !== (m_st == 1) ||
          core_reset !== (m_st != 4) || ready !== (m_st == 4) ||
          lock_loss_cnt !== CW'(m_cnt)) begin
        failures++;
        if (mon_prints < 20)
          $display("FAIL model t=%0t state=%0d exp=%0d pll_rst=%b core_reset=%b ready=%b cnt=%0d exp_cnt=%0d",
                   $time, state_dbg, m_st, pll_rst, core_reset, ready,
                   lock_loss_cnt, m_cnt);
        mon_prints++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ext_reset = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic wait_ready(input int bound);
    int k = 0;
    while (ready !== 1'b1 && k < bound) begin
      cyc(1);
      k++;
    end
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL wait_ready timeout ready=%b required=1", ready);
    end
  endtask

  task automatic test_reset();
    pll_locked = 1'($urandom_range(0, 1));
    ext_reset = 1'($urandom_range(0, 1));
    @(negedge clk);
    rst = 1'b1;
    cyc(3);
    mon_en = 1;
    checks++;
    if (state_dbg !== 3'd0 || core_reset !== 1'b1 || pll_rst !== 1'b0 ||
        ready !== 1'b0 || lock_loss_cnt !== '0) begin
      failures++;
      $display("FAIL reset_values state=%0d core_reset=%b pll_rst=%b ready=%b cnt=%0d required 0/1/0/0/0",
               state_dbg, core_reset, pll_rst, ready, lock_loss_cnt);
    end
    rst = 1'b0;
    ext_reset = 1'b0;
  endtask

  task automatic test_lock_up();
    int n = 0;
    int q_at = -1;
    int r_at = -1;
    int prev = 0;
    bit order_ok = 1;
    pll_locked = 1'b1;
    do_reset();
    while (r_at < 0 && n < 200) begin
      cyc(1);
      n++;
      if (int'(state_dbg) < prev) order_ok = 0;
      prev = int'(state_dbg);
      if (state_dbg == 3'd2 && q_at < 0) q_at = n;
      if (ready === 1'b1 && r_at < 0) r_at = n;
    end
    checks++;
    if (q_at != SS + 1) begin
      failures++;
      $display("FAIL qualify_entry edge=%0d required=%0d", q_at, SS + 1);
    end
    checks++;
    if (r_at - q_at != LS + RH) begin
      failures++;
      $display("FAIL ready_latency edges=%0d required=%0d", r_at - q_at, LS + RH);
    end
    checks++;
    if (!order_ok || core_reset !== 1'b0 || lock_loss_cnt !== '0) begin
      failures++;
      $display("FAIL lock_up_end order_ok=%0d core_reset=%b cnt=%0d required 1/0/0",
               order_ok, core_reset, lock_loss_cnt);
    end
  endtask

  task automatic test_timeout();
    int rises[$];
    int widths[$];
    int width = 0;
    bit prev = 0;
    bit core_ok = 1;
    pll_locked = 1'b0;
    do_reset();
    for (int n = 1; n <= 320; n++) begin
      cyc(1);
      if (pll_rst === 1'b1 && !prev) rises.push_back(n);
      if (pll_rst === 1'b1) width++;
      if (pll_rst !== 1'b1 && prev) begin
        widths.push_back(width);
        width = 0;
      end
      prev = (pll_rst === 1'b1);
      if (core_reset !== 1'b1) core_ok = 0;
    end
    checks++;
    if (rises.size() != 3 || widths.size() != 3) begin
      failures++;
      $display("FAIL pll_rst_pulses rises=%0d widths=%0d required 3/3",
               rises.size(), widths.size());
    end else begin
      checks++;
      if (rises[0] != LT) begin
        failures++;
        $display("FAIL pll_rst_first edge=%0d required=%0d", rises[0], LT);
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (rises[i] - rises[i-1] != LT + PRC) begin
          failures++;
          $display("FAIL pll_rst_period got=%0d required=%0d",
                   rises[i] - rises[i-1], LT + PRC);
        end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (widths[i] != PRC) begin
          failures++;
          $display("FAIL pll_rst_width got=%0d required=%0d", widths[i], PRC);
        end
      end
    end
    checks++;
    if (!core_ok) begin
      failures++;
      $display("FAIL timeout_core_reset dropped=1 required=0");
    end
  endtask

  task automatic test_qualify_drop();
    int k = 0;
    pll_locked = 1'b0;
    do_reset();
    cyc($urandom_range(1, 20));
    pll_locked = 1'b1;
    while (state_dbg !== 3'd2 && k < 10) begin
      cyc(1);
      k++;
    end
    cyc(5);
    pll_locked = 1'b0;
    cyc(3);
    checks++;
    if (state_dbg !== 3'd0 || core_reset !== 1'b1 || lock_loss_cnt !== '0) begin
      failures++;
      $display("FAIL qualify_drop state=%0d core_reset=%b cnt=%0d required 0/1/0",
               state_dbg, core_reset, lock_loss_cnt);
    end
    pll_locked = 1'b1;
    k = 0;
    while (state_dbg !== 3'd2 && k < 10) begin
      cyc(1);
      k++;
    end
    k = 0;
    while (state_dbg === 3'd2 && k < 50) begin
      cyc(1);
      k++;
    end
    checks++;
    if (k != LS || state_dbg !== 3'd3) begin
      failures++;
      $display("FAIL requalify cycles=%0d state=%0d required %0d/3", k, state_dbg, LS);
    end
  endtask

  task automatic test_lock_loss();
    int k;
    int want;
    pll_locked = 1'b1;
    do_reset();
    wait_ready(60);
    for (int i = 0; i < 4; i++) begin
      cyc($urandom_range(1, 30));
      pll_locked = 1'b0;
      k = 0;
      while (core_reset !== 1'b1 && k < 10) begin
        cyc(1);
        k++;
      end
      want = (i + 1 < CMAX) ? i + 1 : CMAX;
      checks++;
      if (k != SS + 1 || lock_loss_cnt !== CW'(want)) begin
        failures++;
        $display("FAIL lock_loss_%0d edges=%0d cnt=%0d required %0d/%0d",
                 i, k, lock_loss_cnt, SS + 1, want);
      end
      cyc($urandom_range(0, 3));
      pll_locked = 1'b1;
      wait_ready(60);
    end
  endtask

  task automatic test_ext_reset();
    int k = 0;
    ext_reset = 1'b1;
    cyc(1);
    ext_reset = 1'b0;
    while (core_reset === 1'b1 && k < 100) begin
      k++;
      cyc(1);
    end
    checks++;
    if (k != RH || ready !== 1'b1) begin
      failures++;
      $display("FAIL ext_single cycles=%0d ready=%b required %0d/1", k, ready, RH);
    end
    cyc($urandom_range(1, 10));
    ext_reset = 1'b1;
    cyc(1);
    ext_reset = 1'b0;
    k = 0;
    while (core_reset === 1'b1 && k < 100) begin
      k++;
      ext_reset = (k == 10);
      cyc(1);
    end
    ext_reset = 1'b0;
    checks++;
    if (k != RH + 10) begin
      failures++;
      $display("FAIL ext_restart cycles=%0d required=%0d", k, RH + 10);
    end
  endtask

  task automatic test_simultaneous();
    pll_locked = 1'b1;
    do_reset();
    wait_ready(60);
    cyc($urandom_range(1, 10));
    pll_locked = 1'b0;
    cyc(2);
    checks++;
    if (state_dbg !== 3'd4) begin
      failures++;
      $display("FAIL simul_pre state=%0d required=4", state_dbg);
    end
    ext_reset = 1'b1;
    cyc(1);
    ext_reset = 1'b0;
    checks++;
    if (state_dbg !== 3'd0 || lock_loss_cnt !== CW'(1) || ready !== 1'b0) begin
      failures++;
      $display("FAIL simul_loss state=%0d cnt=%0d ready=%b required 0/1/0",
               state_dbg, lock_loss_cnt, ready);
    end
  endtask

  task automatic test_rst_mid_hold();
    int k = 0;
    pll_locked = 1'b1;
    while (state_dbg !== 3'd3 && k < 30) begin
      cyc(1);
      k++;
    end
    cyc($urandom_range(1, 10));
    rst = 1'b1;
    cyc(1);
    checks++;
    if (state_dbg !== 3'd0 || core_reset !== 1'b1 || ready !== 1'b0 ||
        pll_rst !== 1'b0 || lock_loss_cnt !== '0) begin
      failures++;
      $display("FAIL rst_mid_hold state=%0d core_reset=%b ready=%b pll_rst=%b cnt=%0d required 0/1/0/0/0",
               state_dbg, core_reset, ready, pll_rst, lock_loss_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_random_soak();
    int total = 0;
    int dur;
    while (total < 4000) begin
      pll_locked = 1'($urandom_range(0, 1));
      dur = $urandom_range(1, 150);
      for (int i = 0; i < dur; i++) begin
        ext_reset = ($urandom_range(0, 49) == 0);
        rst = ($urandom_range(0, 399) == 0);
        cyc(1);
      end
      total += dur;
    end
    rst = 1'b0;
    ext_reset = 1'b0;
    cyc(2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lock_up();
    test_timeout();
    test_qualify_drop();
    test_lock_loss();
    test_ext_reset();
    test_simultaneous();
    test_rst_mid_hold();
    test_random_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
